// File: rtl/traffic_display.sv
// Pedestrian countdown display: registered lamp copies plus a two-digit BCD countdown on a multiplexed 7-segment pair.
// Optional build macro TRAFFIC_DISP_LZB_EN blanks a leading-zero tens digit.
module traffic_display #(
    parameter int unsigned WALK_SEC    = 20,
    parameter int unsigned REFRESH_DIV = 50000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       i_tick,
    input  logic [3:0] i_car,
    input  logic [1:0] i_walker,
    output logic [3:0] o_led_car,
    output logic [1:0] o_led_walker,
    output logic [6:0] o_seg,
    output logic [1:0] o_dig
);

    typedef enum logic [1:0] {BLANK, COUNT, ZERO} state_t;

    localparam logic [3:0]  WALK_TENS = 4'(WALK_SEC / 10);
    localparam logic [3:0]  WALK_ONES = 4'(WALK_SEC % 10);
    localparam logic [15:0] REF_LAST  = 16'(REFRESH_DIV - 1);
    localparam logic [6:0]  SEG_OFF   = 7'b1111111;

    state_t      state_q, state_d;
    logic [3:0]  tens_q, tens_d;
    logic [3:0]  ones_q, ones_d;
    logic [3:0]  led_car_q, led_car_d;
    logic [1:0]  led_walker_q, led_walker_d;
    logic [15:0] ref_q, ref_d;
    logic        sel_q, sel_d;
    logic [6:0]  seg_q, seg_d;
    logic [1:0]  dig_q, dig_d;

    logic        exit_c;
    logic        entry_c;
    logic [3:0]  digit_c;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = SEG_OFF;
        endcase
    endfunction

    always_comb begin
        led_car_d    = i_car;
        led_walker_d = i_walker;
        state_d      = state_q;
        tens_d       = tens_q;
        ones_d       = ones_q;

        // Entry edge uses the registered lamp copies as the previous-cycle walker/car view
        exit_c  = (i_walker == 2'b10) || (i_walker == 2'b00 && i_car == 4'b0000);
        entry_c = (i_walker == 2'b01) &&
                  ((led_walker_q == 2'b10) || (led_walker_q == 2'b00 && led_car_q == 4'b0000));

        if (exit_c) begin
            state_d = BLANK;
        end else begin
            case (state_q)
                BLANK: begin
                    if (entry_c) begin
                        state_d = COUNT;
                        tens_d  = WALK_TENS;
                        ones_d  = WALK_ONES;
                    end
                end
                COUNT: begin
                    if (i_tick) begin
                        if (tens_q == 4'd0 && ones_q == 4'd0) begin
                            state_d = ZERO;
                        end else if (ones_q == 4'd0) begin
                            ones_d = 4'd9;
                            tens_d = tens_q - 4'd1;
                        end else begin
                            ones_d = ones_q - 4'd1;
                        end
                    end
                end
                ZERO:    state_d = ZERO;
                default: state_d = BLANK;
            endcase
        end
    end

    always_comb begin
        ref_d   = (ref_q == REF_LAST) ? '0 : ref_q + 16'd1;
        sel_d   = (ref_q == REF_LAST) ? ~sel_q : sel_q;
        digit_c = sel_q ? tens_q : ones_q;
        dig_d   = sel_q ? 2'b01 : 2'b10;
        seg_d   = SEG_OFF;
        if (state_q != BLANK) begin
            seg_d = seg7(digit_c);
`ifdef TRAFFIC_DISP_LZB_EN
            if (sel_q && tens_q == 4'd0) seg_d = SEG_OFF;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= BLANK;
            tens_q       <= '0;
            ones_q       <= '0;
            led_car_q    <= '0;
            led_walker_q <= '0;
            ref_q        <= '0;
            sel_q        <= 1'b0;
            seg_q        <= '1;
            dig_q        <= '1;
        end else begin
            state_q      <= state_d;
            tens_q       <= tens_d;
            ones_q       <= ones_d;
            led_car_q    <= led_car_d;
            led_walker_q <= led_walker_d;
            ref_q        <= ref_d;
            sel_q        <= sel_d;
            seg_q        <= seg_d;
            dig_q        <= dig_d;
        end
    end

    assign o_led_car    = led_car_q;
    assign o_led_walker = led_walker_q;
    assign o_seg        = seg_q;
    assign o_dig        = dig_q;

endmodule

// File: tb/tb_traffic_display.sv
// Randomized bench for traffic_display against a seconds-level behavioural model of the countdown display.
module tb_traffic_display;

    localparam int WALK = 20;
    localparam int DIV  = 4;
    localparam logic [6:0] GLYPH [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                          7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                          7'b0000000, 7'b0010000};
`ifdef TRAFFIC_DISP_LZB_EN
    localparam logic [6:0] TENS_ZERO = 7'b1111111;
`else
    localparam logic [6:0] TENS_ZERO = 7'b1000000;
`endif

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       i_tick = 1'b0;
    logic [3:0] i_car = 4'b0000;
    logic [1:0] i_walker = 2'b00;
    logic [3:0] o_led_car;
    logic [1:0] o_led_walker;
    logic [6:0] o_seg;
    logic [1:0] o_dig;

    int checks = 0;
    int failures = 0;

    // model: walk phase (0 dark, 1 counting, 2 done), remaining seconds, refresh position
    int         m_phase = 0;
    int         m_secs = 0;
    int         m_ref = 0;
    int         m_sel = 0;
    logic [1:0] m_pw = 2'b00;
    logic [3:0] m_pc = 4'b0000;
    logic [6:0] e_seg = 7'b1111111;
    logic [1:0] e_dig = 2'b11;
    logic [3:0] e_car = 4'b0000;
    logic [1:0] e_walk = 2'b00;

    traffic_display #(.WALK_SEC(WALK), .REFRESH_DIV(DIV)) dut (
        .clk(clk), .reset_n(reset_n), .i_tick(i_tick), .i_car(i_car), .i_walker(i_walker),
        .o_led_car(o_led_car), .o_led_walker(o_led_walker), .o_seg(o_seg), .o_dig(o_dig)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [6:0] got, input logic [6:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%b exp=%b", tag, $time, got, exp);
        end
    endtask

    task automatic model_edge();
        int digit;
        logic leave;
        if (!reset_n) begin
            m_phase = 0; m_secs = 0; m_ref = 0; m_sel = 0;
            m_pw = 2'b00; m_pc = 4'b0000;
            e_seg = 7'b1111111; e_dig = 2'b11; e_car = 4'b0000; e_walk = 2'b00;
        end else begin
            e_car  = i_car;
            e_walk = i_walker;
            e_dig  = (m_sel != 0) ? 2'b01 : 2'b10;
            if (m_phase == 0) begin
                e_seg = 7'b1111111;
            end else begin
                digit = (m_sel != 0) ? m_secs / 10 : m_secs % 10;
                e_seg = GLYPH[digit];
                if (m_sel != 0 && m_secs < 10) e_seg = TENS_ZERO;
            end
            leave = (i_walker == 2'b10) || (i_walker == 2'b00 && i_car == 4'b0000);
            if (leave) m_phase = 0;
            else if (m_phase == 0 && i_walker == 2'b01 &&
                     (m_pw == 2'b10 || (m_pw == 2'b00 && m_pc == 4'b0000))) begin
                m_phase = 1;
                m_secs  = WALK;
            end else if (m_phase == 1 && i_tick) begin
                if (m_secs == 0) m_phase = 2;
                else m_secs = m_secs - 1;
            end
            m_pw = i_walker;
            m_pc = i_car;
            m_ref = m_ref + 1;
            if (m_ref == DIV) begin
                m_ref = 0;
                m_sel = 1 - m_sel;
            end
        end
    endtask

    task automatic step(input logic t, input logic [1:0] w, input logic [3:0] c, input logic rn);
        i_tick = t; i_walker = w; i_car = c; reset_n = rn;
        @(posedge clk);
        model_edge();
        #1;
        check("seg", o_seg, e_seg);
        check("dig", {5'b0, o_dig}, {5'b0, e_dig});
        check("led_car", {3'b0, o_led_car}, {3'b0, e_car});
        check("led_walker", {5'b0, o_led_walker}, {5'b0, e_walk});
    endtask

    // Idle for two refresh periods and check each visible digit against fixed glyphs
    task automatic show_check(input logic [6:0] ones_code, input logic [6:0] tens_code,
                              input logic [1:0] w, input logic [3:0] c);
        for (int k = 0; k < 2 * DIV; k++) begin
            step(1'b0, w, c, 1'b1);
            if (o_dig == 2'b10) check("disp_ones", o_seg, ones_code);
            else check("disp_tens", o_seg, tens_code);
        end
    endtask

    initial begin
        for (int k = 0; k < 3; k++) step(1'b0, 2'($urandom), 4'($urandom), 1'b0);
        check("rst_seg", o_seg, 7'b1111111);
        check("rst_dig", {5'b0, o_dig}, 7'b0000011);

        // entry from red with a coincident tick, then 5 ticks -> 15
        step(1'b0, 2'b10, 4'b0001, 1'b1);
        step(1'b0, 2'b10, 4'b0001, 1'b1);
        step(1'b1, 2'b01, 4'b1000, 1'b1);
        for (int k = 0; k < 5; k++) begin
            step(1'b1, 2'b01, 4'b1000, 1'b1);
            step(1'b0, 2'b01, 4'b1000, 1'b1);
        end
        show_check(7'b0010010, 7'b1111001, 2'b01, 4'b1000);

        // 15 -> 10 -> 09 borrow
        for (int k = 0; k < 5; k++) step(1'b1, 2'b01, 4'b1000, 1'b1);
        show_check(7'b1000000, 7'b1111001, 2'b01, 4'b1000);
        step(1'b1, 2'b01, 4'b1000, 1'b1);
        show_check(7'b0010000, TENS_ZERO, 2'b01, 4'b1000);

        // exit with coincident tick
        step(1'b1, 2'b10, 4'b0001, 1'b1);
        step(1'b0, 2'b10, 4'b0001, 1'b1);
        check("exit_blank", o_seg, 7'b1111111);

        // blinking walker through 21 ticks reaches ZERO, then red exits
        step(1'b0, 2'b01, 4'b1000, 1'b1);
        for (int k = 0; k < 21; k++) begin
            step(1'b1, (k % 2 == 0) ? 2'b00 : 2'b01, 4'b1000, 1'b1);
            step(1'b0, 2'b01, 4'b1000, 1'b1);
        end
        show_check(7'b1000000, TENS_ZERO, 2'b01, 4'b1000);
        step(1'b0, 2'b10, 4'b0001, 1'b1);
        step(1'b0, 2'b10, 4'b0001, 1'b1);
        check("zero_exit", o_seg, 7'b1111111);

        // randomized phases with occasional resets
        for (int p = 0; p < 40; p++) begin
            int kind;
            int len;
            kind = $urandom_range(0, 3);
            len  = $urandom_range(5, 120);
            for (int k = 0; k < len; k++) begin
                logic t;
                logic rn;
                t  = ($urandom_range(0, 3) == 0);
                rn = ($urandom_range(0, 299) != 0);
                case (kind)
                    0:       step(t, 2'b10, 4'b0001, rn);
                    1:       step(t, 2'b01, 4'b1000, rn);
                    2:       step(t, (k % 2 == 0) ? 2'b01 : 2'b00, 4'b1000, rn);
                    default: step(t, 2'b00, 4'b0000, rn);
                endcase
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
